// File: rtl/branch_train_unit.sv
// 64-entry 2-bit branch history table: fetch lookup is combinational, training is 1 cycle after resolve.
// No backpressure: one resolve per cycle is trained, and mispredict/redirect are combinational.
module branch_train_unit #(
  parameter int PC_WIDTH  = 32,
  parameter int IDX_BITS  = 6,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [PC_WIDTH-1:0]  F_PC_i,
  output logic                 F_train_predict_o,
  input  logic                 E_valid_i,
  input  logic                 E_op_branch_i,
  input  logic [PC_WIDTH-1:0]  E_PC_i,
  input  logic                 E_predict_i,
  input  logic                 E_taken_i,
  input  logic [PC_WIDTH-1:0]  E_target_i,
  output logic                 E_mispredict_o,
  output logic [PC_WIDTH-1:0]  E_redirect_pc_o,
  output logic [CNT_WIDTH-1:0] br_count_o,
  output logic [CNT_WIDTH-1:0] mispred_count_o
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]           bht_q [ENTRIES];
  logic [IDX_BITS-1:0]  f_idx;
  logic [IDX_BITS-1:0]  e_idx;
  logic                 res;
  logic [1:0]           cur_ctr;
  logic [1:0]           nxt_ctr;
  logic [CNT_WIDTH-1:0] br_count_q;
  logic [CNT_WIDTH-1:0] br_count_d;
  logic [CNT_WIDTH-1:0] mispred_count_q;
  logic [CNT_WIDTH-1:0] mispred_count_d;
  logic                 unused_fpc_bits;

  assign f_idx           = F_PC_i[IDX_BITS+1:2];
  assign e_idx           = E_PC_i[IDX_BITS+1:2];
  assign unused_fpc_bits = ^{F_PC_i[PC_WIDTH-1:IDX_BITS+2], F_PC_i[1:0]};

  // Reads the registered table only, so a same-cycle write to this entry is not visible yet.
  assign F_train_predict_o = bht_q[f_idx][1];

  assign res             = E_valid_i & E_op_branch_i;
  assign E_mispredict_o  = res & (E_predict_i != E_taken_i);
  assign E_redirect_pc_o = E_taken_i ? E_target_i : E_PC_i + PC_WIDTH'(4);

  assign cur_ctr = bht_q[e_idx];

  always_comb begin
    nxt_ctr = cur_ctr;
    if (E_taken_i) begin
      if (cur_ctr != 2'b11) nxt_ctr = cur_ctr + 2'b01;
    end else begin
      if (cur_ctr != 2'b00) nxt_ctr = cur_ctr - 2'b01;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (res) begin
      bht_q[e_idx] <= nxt_ctr;
    end
  end

  // Performance counters stick at all-ones instead of wrapping.
  assign br_count_d      = (&br_count_q) ? br_count_q : br_count_q + CNT_WIDTH'(1);
  assign mispred_count_d = (&mispred_count_q) ? mispred_count_q : mispred_count_q + CNT_WIDTH'(1);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      if (res)            br_count_q      <= br_count_d;
      if (E_mispredict_o) mispred_count_q <= mispred_count_d;
    end
  end

  assign br_count_o      = br_count_q;
  assign mispred_count_o = mispred_count_q;

endmodule

// File: tb/tb_branch_train_unit.sv
// Directed bench for branch_train_unit: fixed vectors with hand-computed expectations.
module tb_branch_train_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] f_pc;
  logic        f_pred;
  logic        e_valid;
  logic        e_br;
  logic [31:0] e_pc;
  logic        e_pred;
  logic        e_taken;
  logic [31:0] e_tgt;
  logic        e_mis;
  logic [31:0] e_rpc;
  logic [31:0] br_cnt;
  logic [31:0] mis_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] all_ones = 32'hFFFF_FFFF;

  branch_train_unit #(.PC_WIDTH(32), .IDX_BITS(6), .CNT_WIDTH(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .F_PC_i(f_pc), .F_train_predict_o(f_pred),
    .E_valid_i(e_valid), .E_op_branch_i(e_br), .E_PC_i(e_pc), .E_predict_i(e_pred),
    .E_taken_i(e_taken), .E_target_i(e_tgt), .E_mispredict_o(e_mis),
    .E_redirect_pc_o(e_rpc), .br_count_o(br_cnt), .mispred_count_o(mis_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] pc, input logic tk, input logic pr, input logic [31:0] tgt);
    e_valid = 1'b1; e_br = 1'b1; e_pc = pc; e_taken = tk; e_pred = pr; e_tgt = tgt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; f_pc = '0; e_valid = 1'b0; e_br = 1'b0; e_pc = '0;
    e_pred = 1'b0; e_taken = 1'b0; e_tgt = '0;
    #1;
    n_checks++; if (br_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_br_cnt got %0d exp 0", br_cnt); end
    n_checks++; if (mis_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_mis_cnt got %0d exp 0", mis_cnt); end
    for (int a = 0; a < 64; a++) begin
      f_pc = 32'(a * 4);
      #1;
      n_checks++; if (f_pred !== 1'b0) begin n_fail++; $display("FAIL reset_pred pc=%h got %b exp 0", f_pc, f_pred); end
    end
    drive(32'h0, 1'b0, 1'b1, 32'h0);
    #1;
    n_checks++; if (e_mis !== 1'b1) begin n_fail++; $display("FAIL reset_mis_comb got %b exp 1", e_mis); end
    @(negedge clk); e_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_taken_train();
    @(negedge clk);
    drive(32'h40, 1'b1, 1'b0, 32'h100); f_pc = 32'h40;
    #1;
    n_checks++; if (e_mis !== 1'b1) begin n_fail++; $display("FAIL tk1_mis got %b exp 1", e_mis); end
    n_checks++; if (e_rpc !== 32'h100) begin n_fail++; $display("FAIL tk1_rpc got %h exp 00000100", e_rpc); end
    n_checks++; if (f_pred !== 1'b0) begin n_fail++; $display("FAIL tk1_pred got %b exp 0", f_pred); end
    @(negedge clk);
    drive(32'h40, 1'b1, 1'b1, 32'h100);
    #1;
    n_checks++; if (e_mis !== 1'b0) begin n_fail++; $display("FAIL tk2_mis got %b exp 0", e_mis); end
    @(negedge clk); e_valid = 1'b0;
    #1;
    n_checks++; if (f_pred !== 1'b1) begin n_fail++; $display("FAIL tk_pred40 got %b exp 1", f_pred); end
    n_checks++; if (br_cnt !== 32'd2) begin n_fail++; $display("FAIL tk_br_cnt got %0d exp 2", br_cnt); end
    n_checks++; if (mis_cnt !== 32'd1) begin n_fail++; $display("FAIL tk_mis_cnt got %0d exp 1", mis_cnt); end
    f_pc = 32'h44;
    #1;
    n_checks++; if (f_pred !== 1'b0) begin n_fail++; $display("FAIL tk_pred44 got %b exp 0", f_pred); end
  endtask

  task automatic test_not_taken_saturate();
    @(negedge clk);
    repeat (5) begin
      drive(32'h80, 1'b0, 1'b0, 32'h300);
      @(negedge clk);
    end
    e_valid = 1'b0; f_pc = 32'h80;
    #1;
    n_checks++; if (f_pred !== 1'b0) begin n_fail++; $display("FAIL nt_sat_pred got %b exp 0", f_pred); end
    drive(32'h80, 1'b1, 1'b0, 32'h200);
    #1;
    n_checks++; if (e_mis !== 1'b1) begin n_fail++; $display("FAIL nt_tk_mis got %b exp 1", e_mis); end
    n_checks++; if (e_rpc !== 32'h200) begin n_fail++; $display("FAIL nt_tk_rpc got %h exp 00000200", e_rpc); end
    @(negedge clk);
    drive(32'h80, 1'b0, 1'b1, 32'h200);
    #1;
    n_checks++; if (f_pred !== 1'b0) begin n_fail++; $display("FAIL nt_after_tk_pred got %b exp 0", f_pred); end
    n_checks++; if (e_mis !== 1'b1) begin n_fail++; $display("FAIL nt_mis got %b exp 1", e_mis); end
    n_checks++; if (e_rpc !== 32'h84) begin n_fail++; $display("FAIL nt_rpc got %h exp 00000084", e_rpc); end
    @(negedge clk); e_valid = 1'b0;
    #1;
    n_checks++; if (f_pred !== 1'b0) begin n_fail++; $display("FAIL nt_final_pred got %b exp 0", f_pred); end
    n_checks++; if (br_cnt !== 32'd9) begin n_fail++; $display("FAIL nt_br_cnt got %0d exp 9", br_cnt); end
    n_checks++; if (mis_cnt !== 32'd3) begin n_fail++; $display("FAIL nt_mis_cnt got %0d exp 3", mis_cnt); end
  endtask

  task automatic test_redirect_wrap();
    @(negedge clk);
    drive(32'hFFFF_FFFC, 1'b0, 1'b1, 32'h1234);
    #1;
    n_checks++; if (e_rpc !== 32'h0) begin n_fail++; $display("FAIL wrap_rpc got %h exp 00000000", e_rpc); end
    n_checks++; if (e_mis !== 1'b1) begin n_fail++; $display("FAIL wrap_mis got %b exp 1", e_mis); end
    @(negedge clk);
    drive(32'h8, 1'b1, 1'b1, 32'h1000);
    #1;
    n_checks++; if (e_mis !== 1'b0) begin n_fail++; $display("FAIL tkok_mis got %b exp 0", e_mis); end
    n_checks++; if (e_rpc !== 32'h1000) begin n_fail++; $display("FAIL tkok_rpc got %h exp 00001000", e_rpc); end
    @(negedge clk); e_valid = 1'b0;
    #1;
    n_checks++; if (br_cnt !== 32'd11) begin n_fail++; $display("FAIL wrap_br_cnt got %0d exp 11", br_cnt); end
    n_checks++; if (mis_cnt !== 32'd4) begin n_fail++; $display("FAIL wrap_mis_cnt got %0d exp 4", mis_cnt); end
  endtask

  task automatic test_collision();
    @(negedge clk);
    f_pc = 32'h10;
    drive(32'h110, 1'b1, 1'b0, 32'h400);
    #1;
    n_checks++; if (f_pred !== 1'b0) begin n_fail++; $display("FAIL coll_same_cycle got %b exp 0", f_pred); end
    n_checks++; if (e_mis !== 1'b1) begin n_fail++; $display("FAIL coll_mis got %b exp 1", e_mis); end
    @(negedge clk); e_valid = 1'b0;
    #1;
    n_checks++; if (f_pred !== 1'b1) begin n_fail++; $display("FAIL coll_next_cycle got %b exp 1", f_pred); end
    n_checks++; if (br_cnt !== 32'd12) begin n_fail++; $display("FAIL coll_br_cnt got %0d exp 12", br_cnt); end
  endtask

  task automatic test_invalid();
    @(negedge clk);
    f_pc = 32'h10;
    e_valid = 1'b0; e_br = 1'b1; e_pc = 32'h110; e_taken = 1'b0; e_pred = 1'b1; e_tgt = 32'h0;
    #1;
    n_checks++; if (e_mis !== 1'b0) begin n_fail++; $display("FAIL inv_mis got %b exp 0", e_mis); end
    @(negedge clk);
    #1;
    n_checks++; if (f_pred !== 1'b1) begin n_fail++; $display("FAIL inv_pred got %b exp 1", f_pred); end
    e_valid = 1'b1; e_br = 1'b0;
    #1;
    n_checks++; if (e_mis !== 1'b0) begin n_fail++; $display("FAIL nobr_mis got %b exp 0", e_mis); end
    @(negedge clk); e_valid = 1'b0; e_br = 1'b1;
    #1;
    n_checks++; if (f_pred !== 1'b1) begin n_fail++; $display("FAIL nobr_pred got %b exp 1", f_pred); end
    n_checks++; if (br_cnt !== 32'd12) begin n_fail++; $display("FAIL inv_br_cnt got %0d exp 12", br_cnt); end
    n_checks++; if (mis_cnt !== 32'd5) begin n_fail++; $display("FAIL inv_mis_cnt got %0d exp 5", mis_cnt); end
  endtask

  task automatic test_counter_saturate();
    @(negedge clk);
    force dut.br_count_q = 32'hFFFF_FFFF;
    force dut.mispred_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.br_count_q;
    release dut.mispred_count_q;
    #1;
    n_checks++; if (br_cnt !== all_ones) begin n_fail++; $display("FAIL preload_br got %h exp %h", br_cnt, all_ones); end
    drive(32'h200, 1'b1, 1'b0, 32'h500);
    @(negedge clk); e_valid = 1'b0;
    #1;
    n_checks++; if (br_cnt !== all_ones) begin n_fail++; $display("FAIL sat_br got %h exp %h", br_cnt, all_ones); end
    n_checks++; if (mis_cnt !== all_ones) begin n_fail++; $display("FAIL sat_mis got %h exp %h", mis_cnt, all_ones); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    repeat (3) begin
      drive(32'h80, 1'b1, 1'b1, 32'h0);
      @(negedge clk);
    end
    f_pc = 32'h80;
    drive(32'h80, 1'b0, 1'b1, 32'h0);
    #1;
    n_checks++; if (f_pred !== 1'b1) begin n_fail++; $display("FAIL mid_pre_pred got %b exp 1", f_pred); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (f_pred !== 1'b0) begin n_fail++; $display("FAIL mid_rst_pred got %b exp 0", f_pred); end
    n_checks++; if (br_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_rst_br got %0d exp 0", br_cnt); end
    n_checks++; if (mis_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_rst_mis_cnt got %0d exp 0", mis_cnt); end
    n_checks++; if (e_mis !== 1'b1) begin n_fail++; $display("FAIL mid_rst_mis_comb got %b exp 1", e_mis); end
    f_pc = 32'h40;
    #1;
    n_checks++; if (f_pred !== 1'b0) begin n_fail++; $display("FAIL mid_rst_pred40 got %b exp 0", f_pred); end
    @(negedge clk);
    rst_n = 1'b1; e_valid = 1'b0; f_pc = 32'h80;
    #1;
    n_checks++; if (f_pred !== 1'b0) begin n_fail++; $display("FAIL mid_post_pred got %b exp 0", f_pred); end
    drive(32'h80, 1'b1, 1'b0, 32'h0);
    @(negedge clk); e_valid = 1'b0;
    #1;
    n_checks++; if (f_pred !== 1'b1) begin n_fail++; $display("FAIL mid_retrain_pred got %b exp 1", f_pred); end
    n_checks++; if (br_cnt !== 32'd1) begin n_fail++; $display("FAIL mid_retrain_br got %0d exp 1", br_cnt); end
    n_checks++; if (mis_cnt !== 32'd1) begin n_fail++; $display("FAIL mid_retrain_mis got %0d exp 1", mis_cnt); end
  endtask

  initial begin
    test_reset();
    test_taken_train();
    test_not_taken_saturate();
    test_redirect_wrap();
    test_collision();
    test_invalid();
    test_counter_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
